// File: rtl/smem_dram_arbiter.sv
// Round-robin arbiter that lets N SMEM BWT-extend lanes share one DRAM occurrence-table port.
// An in-order tag FIFO records each issuing lane so that in-order responses can be steered back to it.
module smem_dram_arbiter #(
    parameter int NUM_LANES       = 4,
    parameter int LANE_W          = 2,
    parameter int MAX_OUTSTANDING = 16,
    parameter int CNT_W           = 5,
    parameter int ADDR_W          = 32,
    parameter int RESP_W          = 768
) (
    input  logic                        Clk_32UI,
    input  logic                        reset_BWT_extend,
    input  logic [NUM_LANES-1:0]        lane_req_valid,
    output logic [NUM_LANES-1:0]        lane_req_ready,
    input  logic [NUM_LANES*ADDR_W-1:0] lane_addr_k,
    input  logic [NUM_LANES*ADDR_W-1:0] lane_addr_l,
    input  logic                        DRAM_ready,
    output logic                        DRAM_valid,
    output logic [ADDR_W-1:0]           addr_k,
    output logic [ADDR_W-1:0]           addr_l,
    input  logic                        DRAM_get,
    input  logic [RESP_W-1:0]           DRAM_resp,
    output logic [NUM_LANES-1:0]        lane_resp_valid,
    output logic [RESP_W-1:0]           lane_resp_data,
    output logic [CNT_W-1:0]            outstanding,
    output logic                        resp_underflow
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [LANE_W:0]    NUM_LANES_W = (LANE_W+1)'(NUM_LANES);
    localparam logic [LANE_W-1:0]  LAST_LANE   = LANE_W'(NUM_LANES - 1);
    localparam logic [CNT_W-1:0]   MAX_CNT     = CNT_W'(MAX_OUTSTANDING);

    logic [LANE_W-1:0]    rr_q, rr_d;
    logic                 dram_valid_q, dram_valid_d;
    logic [ADDR_W-1:0]    addr_k_q, addr_k_d;
    logic [ADDR_W-1:0]    addr_l_q, addr_l_d;
    logic [NUM_LANES-1:0] resp_valid_q, resp_valid_d;
    logic [RESP_W-1:0]    resp_data_q, resp_data_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 underflow_q, underflow_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LANE_W-1:0]    tag_mem_q [MAX_OUTSTANDING];

    logic                 can_issue;
    logic                 found;
    logic                 push;
    logic                 pop;
    logic                 fifo_empty;
    logic [LANE_W-1:0]    gnt_id;
    logic [LANE_W-1:0]    head_id;
    logic [LANE_W:0]      sum;

    assign fifo_empty = (cnt_q == '0);
    assign can_issue  = DRAM_ready && (cnt_q < MAX_CNT);
    assign pop        = DRAM_get && !fifo_empty;
    assign head_id    = tag_mem_q[rd_ptr_q];

    // Search upward from rr_q; the first valid lane found wins.
    always_comb begin
        found  = 1'b0;
        gnt_id = '0;
        sum    = '0;
        for (int off = 0; off < NUM_LANES; off++) begin
            sum = {1'b0, rr_q} + (LANE_W+1)'(off);
            if (sum >= NUM_LANES_W) begin
                sum = sum - NUM_LANES_W;
            end
            if (!found && lane_req_valid[sum[LANE_W-1:0]]) begin
                found  = 1'b1;
                gnt_id = sum[LANE_W-1:0];
            end
        end
    end

    assign push = can_issue && found;

    always_comb begin
        lane_req_ready = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_req_ready[i] = push && (gnt_id == LANE_W'(i));
        end
    end

    always_comb begin
        rr_d         = rr_q;
        dram_valid_d = push;
        addr_k_d     = addr_k_q;
        addr_l_d     = addr_l_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = cnt_q;
        resp_valid_d = '0;
        resp_data_d  = resp_data_q;
        underflow_d  = underflow_q || (DRAM_get && fifo_empty);
        if (push) begin
            rr_d     = (gnt_id == LAST_LANE) ? '0 : gnt_id + LANE_W'(1);
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            for (int i = 0; i < NUM_LANES; i++) begin
                if (gnt_id == LANE_W'(i)) begin
                    addr_k_d = lane_addr_k[i*ADDR_W +: ADDR_W];
                    addr_l_d = lane_addr_l[i*ADDR_W +: ADDR_W];
                end
            end
        end
        if (pop) begin
            rd_ptr_d    = rd_ptr_q + PTR_W'(1);
            resp_data_d = DRAM_resp;
            for (int i = 0; i < NUM_LANES; i++) begin
                resp_valid_d[i] = (head_id == LANE_W'(i));
            end
        end
        // Simultaneous push and pop leave the occupancy unchanged.
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge Clk_32UI or negedge reset_BWT_extend) begin
        if (!reset_BWT_extend) begin
            rr_q         <= '0;
            dram_valid_q <= 1'b0;
            addr_k_q     <= '0;
            addr_l_q     <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            cnt_q        <= '0;
            underflow_q  <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            rr_q         <= rr_d;
            dram_valid_q <= dram_valid_d;
            addr_k_q     <= addr_k_d;
            addr_l_q     <= addr_l_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            cnt_q        <= cnt_d;
            underflow_q  <= underflow_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    // Tag storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge Clk_32UI) begin
        if (push) begin
            tag_mem_q[wr_ptr_q] <= gnt_id;
        end
    end

    assign DRAM_valid      = dram_valid_q;
    assign addr_k          = addr_k_q;
    assign addr_l          = addr_l_q;
    assign lane_resp_valid = resp_valid_q;
    assign lane_resp_data  = resp_data_q;
    assign outstanding     = cnt_q;
    assign resp_underflow  = underflow_q;

endmodule

// File: doc/smem_dram_arbiter.md
Name: smem_dram_arbiter

Overview:
- Parametrised N-lane arbiter between SMEM BWT-extend pipeline lanes and the single DRAM occurrence-table port.
- Lets several Datapath/Queue lanes share one addr_k/addr_l request channel and one in-order cnt/cntl response channel.
- Grants lane requests round-robin and records the issuing lane ID in an in-order tag FIFO.
- Steers each DRAM response back to the lane that issued the matching request.

Parameters:
- NUM_LANES, 4, number of pipeline lanes; 2..8.
- LANE_W, 2, lane ID width; equals clog2(NUM_LANES).
- MAX_OUTSTANDING, 16, tag FIFO depth; power of two, 2..64.
- CNT_W, 5, outstanding-counter width; equals clog2(MAX_OUTSTANDING)+1.
- ADDR_W, 32, width of addr_k and addr_l.
- RESP_W, 768, response payload width: {cntl_b3..b0, cntl_a3..a0, cnt_b3..b0, cnt_a3..a0}.

Ports:
- Clk_32UI  in  1  clock.
- reset_BWT_extend  in  1  asynchronous, active-low reset.
- lane_req_valid  in  NUM_LANES  per-lane request valid.
- lane_req_ready  out  NUM_LANES  per-lane grant, one-hot or zero, combinational.
- lane_addr_k  in  NUM_LANES*ADDR_W  per-lane k address; lane i occupies bits [i*ADDR_W +: ADDR_W].
- lane_addr_l  in  NUM_LANES*ADDR_W  per-lane l address; same packing as lane_addr_k.
- DRAM_ready  in  1  DRAM can accept a request this cycle.
- DRAM_valid  out  1  request issue pulse, registered.
- addr_k  out  ADDR_W  issued k address, registered.
- addr_l  out  ADDR_W  issued l address, registered.
- DRAM_get  in  1  response valid; responses arrive in issue order.
- DRAM_resp  in  RESP_W  response payload.
- lane_resp_valid  out  NUM_LANES  one-hot response strobe, registered.
- lane_resp_data  out  RESP_W  response payload, registered, shared by all lanes.
- outstanding  out  CNT_W  number of requests issued but not yet answered.
- resp_underflow  out  1  sticky error flag.

Behaviour:
- Reset (async, reset_BWT_extend=0) clears:
  - DRAM_valid, addr_k, addr_l, lane_resp_valid, lane_resp_data, outstanding, resp_underflow to 0.
  - Round-robin pointer to lane 0.
  - Tag FIFO pointers to 0, so the FIFO is empty.
- Reset asserted mid-operation discards all in-flight tags. Responses that arrive after reset releases raise resp_underflow.
- Arbitration (combinational):
  - can_issue = DRAM_ready && (outstanding < MAX_OUTSTANDING).
  - If can_issue, the grant goes to the first lane with lane_req_valid=1 searching upward from rr_ptr, wrapping modulo NUM_LANES.
  - lane_req_ready is one-hot on the granted lane. It is all-zero if can_issue=0 or no lane is valid.
  - A handshake completes when lane_req_valid[i] && lane_req_ready[i].
- Issue (registered):
  - On a handshake at cycle t: DRAM_valid=1 at t+1; addr_k/addr_l hold the granted lane's addresses at t+1; the lane ID is pushed into the tag FIFO; rr_ptr becomes (granted+1) mod NUM_LANES.
  - With no handshake, DRAM_valid=0 at t+1, addr_k/addr_l hold their values, and rr_ptr is unchanged.
  - Exactly one request issues per cycle, at most.
- Response:
  - On DRAM_get at cycle t with the FIFO non-empty: pop the head lane ID h. At t+1, lane_resp_valid[h]=1 (only bit h) and lane_resp_data=DRAM_resp sampled at t.
  - Otherwise lane_resp_valid=0 at t+1 and lane_resp_data holds its value.
  - DRAM_get with the FIFO empty: no pop, no strobe, resp_underflow set to 1. It stays 1 until reset.
- Outstanding counter:
  - +1 on push, -1 on pop, unchanged when both happen in the same cycle.
  - Never exceeds MAX_OUTSTANDING and never wraps below 0.
  - outstanding always equals the FIFO occupancy.
- Full:
  - When outstanding==MAX_OUTSTANDING, no grant is given, even if a pop happens in the same cycle.
  - Grants resume the cycle after occupancy drops.
- Simultaneous events: push and pop in the same cycle are both legal when the FIFO is not full, with the FIFO non-empty for the pop.
- FIFO addressing: read and write pointers wrap modulo MAX_OUTSTANDING.
- Round-trip latency added by this block: 1 cycle on the request path, 1 cycle on the response path.

Test Plan:
- Reset then idle: outputs all 0. Assert lane 2 valid with addr_k=0x100, addr_l=0x1FF and DRAM_ready=1 -> lane_req_ready=0100; next cycle DRAM_valid=1, addr_k=0x100, addr_l=0x1FF, outstanding=1.
- Lanes 0..3 all valid continuously with DRAM_ready=1 -> grants in order 0,1,2,3,0,1; one DRAM_valid pulse per cycle. Return 6 DRAM_get with payloads 1..6 -> lane_resp_valid sequence 0001,0010,0100,1000,0001,0010 with matching data.
- Fill to 16 outstanding with no responses -> lane_req_ready=0 while outstanding=16. One DRAM_get -> outstanding=15 next cycle, then one grant in the following cycle.
- DRAM_ready=0 for 5 cycles with lanes 1 and 3 valid -> no grants, no DRAM_valid, rr_ptr unchanged. DRAM_ready=1 -> lane 1 granted first.
- DRAM_get with the FIFO empty -> no lane_resp_valid, resp_underflow=1 and it stays set. Reset mid-run with 3 outstanding -> outstanding=0 and resp_underflow=0 immediately.
- Same-cycle handshake and DRAM_get at outstanding=7 -> outstanding stays 7; the response goes to the oldest lane and the new tag is appended.
